// File: rtl/memory_controller.sv
// ---------------------------------------------------------------------------
// Module     : memory_controller
// Description: PDP-8 main memory (4096 x 12) with a single shared access
//              port, per-word written/valid tracking and one trace record
//              per completed access.
// Revision   : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module memory_controller #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_enable,
  input  logic                  read_type,
  input  logic                  write_enable,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic                  uninit_read,
  output logic                  trace_valid,
  output logic [1:0]            trace_kind,
  output logic [ADDR_WIDTH-1:0] trace_addr,
  output logic [DATA_WIDTH-1:0] trace_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [1:0] c_KIND_DATA_READ  = 2'd0;
  localparam logic [1:0] c_KIND_DATA_WRITE = 2'd1;
  localparam logic [1:0] c_KIND_INSTR_FETCH = 2'd2;

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [DEPTH-1:0]      r_valid;

  logic [DATA_WIDTH-1:0] r_read_data;
  logic                  r_read_valid;
  logic                  r_uninit_read;
  logic                  r_trace_valid;
  logic [1:0]            r_trace_kind;
  logic [ADDR_WIDTH-1:0] r_trace_addr;
  logic [DATA_WIDTH-1:0] r_trace_data;

  logic [DATA_WIDTH-1:0] w_access_data;
  logic                  w_word_valid;
  logic [1:0]            w_kind;

  // The port has one address, so a simultaneous read and write always target
  // the same word; the read is write-first and sees the incoming data.
  always_comb begin
    w_access_data = write_enable ? write_data : r_mem[address];
    w_word_valid  = write_enable | r_valid[address];
    if (write_enable) begin
      w_kind = c_KIND_DATA_WRITE;
    end else if (read_type) begin
      w_kind = c_KIND_INSTR_FETCH;
    end else begin
      w_kind = c_KIND_DATA_READ;
    end
  end

  // RAM has no reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (write_enable && !reset) begin
      r_mem[address] <= write_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
    end else if (write_enable) begin
      r_valid[address] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_read_data   <= '0;
      r_read_valid  <= 1'b0;
      r_uninit_read <= 1'b0;
    end else begin
      r_read_valid  <= read_enable;
      r_uninit_read <= read_enable & ~w_word_valid;
      if (read_enable) begin
        r_read_data <= w_access_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_trace_valid <= 1'b0;
      r_trace_kind  <= c_KIND_DATA_READ;
      r_trace_addr  <= '0;
      r_trace_data  <= '0;
    end else begin
      r_trace_valid <= read_enable | write_enable;
      if (read_enable || write_enable) begin
        r_trace_kind <= w_kind;
        r_trace_addr <= address;
        r_trace_data <= w_access_data;
      end
    end
  end

  assign read_data   = r_read_data;
  assign read_valid  = r_read_valid;
  assign uninit_read = r_uninit_read;
  assign trace_valid = r_trace_valid;
  assign trace_kind  = r_trace_kind;
  assign trace_addr  = r_trace_addr;
  assign trace_data  = r_trace_data;

endmodule

`default_nettype wire

// File: tb/tb_memory_controller.sv
// ---------------------------------------------------------------------------
// Module     : tb_memory_controller
// Description: Randomised self-checking bench for memory_controller against
//              a word-array reference model.
// Revision   : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_memory_controller;

  localparam int AW = 12;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] address;
  logic [DW-1:0] write_data;
  logic          read_enable;
  logic          read_type;
  logic          write_enable;
  logic [DW-1:0] read_data;
  logic          read_valid;
  logic          uninit_read;
  logic          trace_valid;
  logic [1:0]    trace_kind;
  logic [AW-1:0] trace_addr;
  logic [DW-1:0] trace_data;

  memory_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .write_data  (write_data),
    .read_enable (read_enable),
    .read_type   (read_type),
    .write_enable(write_enable),
    .read_data   (read_data),
    .read_valid  (read_valid),
    .uninit_read (uninit_read),
    .trace_valid (trace_valid),
    .trace_kind  (trace_kind),
    .trace_addr  (trace_addr),
    .trace_data  (trace_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: word contents (known only once written), written-since-reset flags.
  logic [DW-1:0] m_mem   [4096];
  bit            m_known [4096];
  bit            m_valid [4096];
  logic [DW-1:0] e_rd;
  bit            e_rd_known;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0o expected %0o", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, ".read_data"},   32'(read_data),   32'd0);
    check_value({tag, ".read_valid"},  32'(read_valid),  32'd0);
    check_value({tag, ".uninit_read"}, 32'(uninit_read), 32'd0);
    check_value({tag, ".trace_valid"}, 32'(trace_valid), 32'd0);
    check_value({tag, ".trace_kind"},  32'(trace_kind),  32'd0);
    check_value({tag, ".trace_addr"},  32'(trace_addr),  32'd0);
    check_value({tag, ".trace_data"},  32'(trace_data),  32'd0);
  endtask

  // One clock of access; checks the registered results one edge later.
  task automatic access(input bit re, input bit rt, input bit we,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    int kind;
    @(negedge clk);
    read_enable  = re;
    read_type    = rt;
    write_enable = we;
    address      = a;
    write_data   = d;
    @(posedge clk);
    #1;
    kind = we ? 1 : (rt ? 2 : 0);
    check_value("read_valid",  32'(read_valid),  32'(re));
    check_value("uninit_read", 32'(uninit_read), 32'(re && !we && !m_valid[a]));
    check_value("trace_valid", 32'(trace_valid), 32'(re || we));
    if (re || we) begin
      check_value("trace_kind", 32'(trace_kind), 32'(kind));
      check_value("trace_addr", 32'(trace_addr), 32'(a));
      if (we) check_value("trace_data", 32'(trace_data), 32'(d));
      else if (m_known[a]) check_value("trace_data", 32'(trace_data), 32'(m_mem[a]));
    end
    if (re) begin
      e_rd       = we ? d : m_mem[a];
      e_rd_known = we || m_known[a];
    end
    if (e_rd_known) check_value("read_data", 32'(read_data), 32'(e_rd));
    if (we) begin
      m_mem[a]   = d;
      m_known[a] = 1'b1;
      m_valid[a] = 1'b1;
    end
    read_enable  = 1'b0;
    write_enable = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4096; i++) m_valid[i] = 1'b0;
    e_rd       = '0;
    e_rd_known = 1'b1;
  endtask

  initial begin
    reset        = 1'b1;
    address      = '0;
    write_data   = '0;
    read_enable  = 1'b0;
    read_type    = 1'b0;
    write_enable = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      m_mem[i]   = '0;
      m_known[i] = 1'b0;
    end
    model_reset();
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    reset = 1'b0;

    // Uninitialised data read, then write followed by read of the same word.
    access(1, 0, 0, 12'o0200, 12'o0);
    access(0, 0, 1, 12'o0200, 12'o0333);
    access(1, 0, 0, 12'o0200, 12'o0);
    access(0, 0, 0, 12'o0, 12'o0);

    // Address-as-data sweep over 0000..7776.
    for (int a = 0; a < 4095; a++) begin
      access(0, 0, 1, 12'(a), 12'(a));
      access(1, 0, 0, 12'(a), 12'o0);
    end

    // Instruction fetch of the top word.
    access(0, 0, 1, 12'o7777, 12'o7402);
    access(1, 1, 0, 12'o7777, 12'o0);

    // Same-cycle write and read: write-first, single trace pulse.
    access(1, 0, 1, 12'o0050, 12'o1234);
    access(0, 0, 0, 12'o0, 12'o0);
    access(1, 1, 1, 12'o0051, 12'o4321);

    // Reset mid-stream clears valid bits and drops a write seen during reset.
    access(0, 0, 1, 12'o0010, 12'o0001);
    @(negedge clk);
    #2;
    reset        = 1'b1;
    write_enable = 1'b1;
    read_enable  = 1'b1;
    address      = 12'o0010;
    write_data   = 12'o7777;
    #1;
    check_reset_outputs("rst_async");
    @(posedge clk);
    #1;
    check_reset_outputs("rst_edge");
    @(negedge clk);
    reset        = 1'b0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    model_reset();
    access(1, 0, 0, 12'o0010, 12'o0);
    access(1, 1, 0, 12'o0200, 12'o0);

    // Randomised mix over a small address window so words get revisited.
    for (int i = 0; i < 600; i++) begin
      logic [AW-1:0] ra;
      logic [DW-1:0] rd;
      int            op;
      ra = 12'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) ra = 12'($urandom);
      rd = 12'($urandom);
      op = $urandom_range(0, 7);
      case (op)
        0, 1, 2: access(1, 0, 0, ra, rd);
        3, 4:    access(0, 0, 1, ra, rd);
        5:       access(1, 1'($urandom), 1, ra, rd);
        6:       access(1, 1, 0, ra, rd);
        default: access(0, 1'($urandom), 0, ra, rd);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
